reg_writeback: RTL
==================

# reg_writeback

Writeback stage of the pipelined datapath and the write-side counterpart of register fetch. It accepts completed results from execute through a valid/ready handshake and buffers them in order in a small FIFO. For loads it waits for the memory response and sign- or zero-extends it to DBITS. It then drives the register file write port (wrtEn, rd, wrtData), one write per cycle, in program order.

## Interface
- REG_INDEX_BIT_WIDTH, 4, register index width
- DBITS, 32, datapath width
- FIFO_DEPTH, 4, pending-result entries; power of two, ≥2
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- inValid  in  1  execute result valid
- inReady  out  1  stage can accept; = !reset && count < FIFO_DEPTH
- inRd  in  REG_INDEX_BIT_WIDTH  destination register
- inData  in  DBITS  ALU result (ignored for loads)
- inIsLoad  in  1  result comes from memory response
- inSize  in  2  load size: 00 byte, 01 half, 10/11 word
- inSigned  in  1  1 = sign-extend load, 0 = zero-extend
- memValid  in  1  memory response valid (one per load, in order)
- memData  in  DBITS  memory response data
- wrtEn  out  1  register file write enable
- wrtRd  out  REG_INDEX_BIT_WIDTH  write index
- wrtData  out  DBITS  write data
- errFlag  out  1  sticky: memValid received with no load at FIFO head
- fwdRs1, fwdRs2  in  REG_INDEX_BIT_WIDTH  fetch source indices (WB_FORWARD_EN only)
- fwdHit1, fwdHit2  out  1  forward valid (WB_FORWARD_EN only)
- fwdData1, fwdData2  out  DBITS  forwarded value (WB_FORWARD_EN only)
- stall  out  1  source depends on a still-pending entry (WB_FORWARD_EN only)

## Operation
- Push: when inValid && inReady, store {inRd, inData, inIsLoad, inSize, inSigned} at the tail.
- Head retire, at most one per cycle:
  - A non-load head retires immediately.
  - A load head retires in the cycle memValid is high.
  - Otherwise the head waits (state WAIT_MEM).
- FSM states: EMPTY (count=0), READY (head non-load), WAIT_MEM (head load, no memValid).
  - Transitions follow count and head type after each push/pop.
- Retire registers wrtEn=1 for one cycle with wrtRd=head rd and wrtData as follows:
  - non-load: stored data.
  - byte load: memData[7:0], extended.
  - half load: memData[15:0], extended.
  - word load: memData unchanged.
  - Extension: bit 7 or 15 replicated if inSigned, else zeros.
- rd == 0: entry retires normally, but wrtEn stays 0 (r0 is never written).
- memValid while FIFO empty or head non-load: response dropped; errFlag set until reset; FIFO unaffected.
- Simultaneous push and pop: both occur; count unchanged.
- Full FIFO: inReady=0; a pop in the same cycle does not raise inReady until the next cycle (no combinational ready path).

## Timing
- Reset values: wrtEn=0, wrtRd=0, wrtData=0, errFlag=0, count=0, inReady=0 while reset is high; fwdHit*=0, stall=0.
- Reset mid-operation: all entries discarded; memValid during reset ignored; no write issued after reset.
- Latency, non-load: accepted at edge N, retires at edge N+1, wrtEn high in cycle N+1..N+2.
- Latency, load: wrtEn high in the cycle after the first memValid at which the load is head.
- Throughput: one write per cycle sustained for back-to-back non-loads.

## Configuration
- WB_FORWARD_EN defined:
  - fwdHit1/2 = wrtEn && fwdRs == wrtRd; fwdData = wrtData. This covers the value being written this cycle, which the register file returns stale.
  - stall = 1 when a nonzero fwdRs1 or fwdRs2 matches rd of any valid FIFO entry.
- WB_FORWARD_EN undefined: the fwd*/stall ports and their logic are absent; fetch must interlock externally.

## Test plan
- Reset, then push non-load rd=3, data=0x12345678 -> wrtEn=1, wrtRd=3, wrtData=0x12345678 exactly 2 cycles after acceptance.
- Load rd=5, size=00, signed=1, memValid with memData=0x000000F0 -> wrtData=0xFFFFFFF0. Repeat with signed=0 -> 0x000000F0. Size=01 signed, memData=0x00008001 -> 0xFFFF8001.
- Push load, then 4 non-loads with memValid held low -> inReady drops at count=4, no writes. memValid pulse -> 5 writes in order on consecutive cycles.
- memValid while empty -> errFlag=1, no write, stays set until reset. Non-load with rd=0 -> wrtEn stays 0.
- Assert reset with 3 entries pending and memValid high -> all outputs return to 0, no subsequent writes.
- WB_FORWARD_EN: pending load rd=7, fwdRs1=7 -> stall=1. On its write cycle -> stall=0, fwdHit1=1, fwdData1=wrtData.

Source files
------------

// File: rtl/reg_writeback.sv
// Writeback stage: buffers execute results in order, waits for load data, drives the RF write port.
// Optional forwarding/interlock outputs are built when WB_FORWARD_EN is defined.
module reg_writeback #(
  parameter int unsigned REG_INDEX_BIT_WIDTH = 4,
  parameter int unsigned DBITS               = 32,
  parameter int unsigned FIFO_DEPTH          = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] inRd,
  input  logic [DBITS-1:0]               inData,
  input  logic                           inIsLoad,
  input  logic [1:0]                     inSize,
  input  logic                           inSigned,
  input  logic                           memValid,
  input  logic [DBITS-1:0]               memData,
`ifdef WB_FORWARD_EN
  input  logic [REG_INDEX_BIT_WIDTH-1:0] fwdRs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] fwdRs2,
  output logic                           fwdHit1,
  output logic                           fwdHit2,
  output logic [DBITS-1:0]               fwdData1,
  output logic [DBITS-1:0]               fwdData2,
  output logic                           stall,
`endif
  output logic                           wrtEn,
  output logic [REG_INDEX_BIT_WIDTH-1:0] wrtRd,
  output logic [DBITS-1:0]               wrtData,
  output logic                           errFlag
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {StEmpty, StReady, StWaitMem} state_e;

  logic [REG_INDEX_BIT_WIDTH-1:0] rd_mem     [FIFO_DEPTH];
  logic [DBITS-1:0]               data_mem   [FIFO_DEPTH];
  logic                           load_mem   [FIFO_DEPTH];
  logic [1:0]                     size_mem   [FIFO_DEPTH];
  logic                           signed_mem [FIFO_DEPTH];

  state_e                         state_q, state_d;
  logic [PtrW-1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]                count_q, count_d, remain;
  logic                           err_q, err_d;
  logic                           wrt_en_q, wrt_en_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] wrt_rd_q, wrt_rd_d;
  logic [DBITS-1:0]               wrt_data_q, wrt_data_d;

  logic                           push, pop, head_is_load, next_head_load;
  logic [REG_INDEX_BIT_WIDTH-1:0] head_rd;
  logic [DBITS-1:0]               head_data, load_data;
  logic [1:0]                     head_size;
  logic                           head_signed;

  // Ready depends only on registered count, so a same-cycle pop never opens the input.
  assign inReady      = !reset && (count_q < CntW'(FIFO_DEPTH));
  assign push         = inValid && inReady;
  assign head_is_load = (state_q == StWaitMem);
  assign pop          = (state_q != StEmpty) && (!head_is_load || memValid);

  assign head_rd     = rd_mem[rd_ptr_q];
  assign head_data   = data_mem[rd_ptr_q];
  assign head_size   = size_mem[rd_ptr_q];
  assign head_signed = signed_mem[rd_ptr_q];

  always_comb begin
    load_data = memData;
    case (head_size)
      2'b00:   load_data = {{(DBITS - 8){head_signed & memData[7]}}, memData[7:0]};
      2'b01:   load_data = {{(DBITS - 16){head_signed & memData[15]}}, memData[15:0]};
      default: load_data = memData;
    endcase
  end

  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    err_d          = err_q;
    wrt_en_d       = 1'b0;
    wrt_rd_d       = wrt_rd_q;
    wrt_data_d     = wrt_data_q;
    state_d        = state_q;
    next_head_load = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      wrt_en_d   = (head_rd != '0);
      wrt_rd_d   = head_rd;
      wrt_data_d = head_is_load ? load_data : head_data;
    end
    // A response is only legal when a load sits at the head.
    if (memValid && !head_is_load) err_d = 1'b1;

    count_d = count_q + CntW'(push) - CntW'(pop);
    remain  = count_q - CntW'(pop);
    if (remain == '0) next_head_load = inIsLoad;
    else              next_head_load = load_mem[rd_ptr_d];

    if (count_d == '0)       state_d = StEmpty;
    else if (next_head_load) state_d = StWaitMem;
    else                     state_d = StReady;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEmpty;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      wrt_en_q   <= 1'b0;
      wrt_rd_q   <= '0;
      wrt_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      wrt_en_q   <= wrt_en_d;
      wrt_rd_q   <= wrt_rd_d;
      wrt_data_q <= wrt_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr_q]     <= inRd;
      data_mem[wr_ptr_q]   <= inData;
      load_mem[wr_ptr_q]   <= inIsLoad;
      size_mem[wr_ptr_q]   <= inSize;
      signed_mem[wr_ptr_q] <= inSigned;
    end
  end

  assign wrtEn   = wrt_en_q;
  assign wrtRd   = wrt_rd_q;
  assign wrtData = wrt_data_q;
  assign errFlag = err_q;

`ifdef WB_FORWARD_EN
  logic [PtrW-1:0] scan_idx;
  logic            stall_hit;

  assign fwdHit1  = wrt_en_q && (fwdRs1 == wrt_rd_q);
  assign fwdHit2  = wrt_en_q && (fwdRs2 == wrt_rd_q);
  assign fwdData1 = wrt_data_q;
  assign fwdData2 = wrt_data_q;

  always_comb begin
    stall_hit = 1'b0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      scan_idx = rd_ptr_q + PtrW'(k);
      if (CntW'(k) < count_q) begin
        if ((fwdRs1 != '0) && (rd_mem[scan_idx] == fwdRs1)) stall_hit = 1'b1;
        if ((fwdRs2 != '0) && (rd_mem[scan_idx] == fwdRs2)) stall_hit = 1'b1;
      end
    end
  end

  assign stall = stall_hit;
`endif

endmodule
